lpc_io_target: RTL and testbench
================================

// Module: lpc_io_target
// PURPOSE
//  LPC bus-side I/O target FSM. Decodes host LPC I/O read/write cycles on LFrame_n/LAD and presents byte
//  accesses to the FPGA register bank (32 x 8-bit window). Drives Addr/Wr/DataWr into the register file and
//  returns RdData on LAD. Sits between the LPC pins and the register bank inside the Lpc hierarchy.
// PARAMETERS
//  BASE_ADDR   16'h0800  I/O base of register window; must be 32-byte aligned
//  NUM_REGS    32        window size in bytes (power of 2, <=256)
// PORTS
//  LpcClock    in   1   33 MHz LPC clock; single clock domain
//  PciReset    in   1   synchronous, active-high reset
//  LFrame_n    in   1   LPC LFRAME#, active low
//  LAD_in      in   4   LAD sampled from pins
//  LAD_out     out  4   LAD drive value
//  LAD_oe      out  1   1 = drive LAD_out onto pins
//  Addr        out  8   register index = io_addr[log2(NUM_REGS)-1:0], zero-extended
//  Wr          out  1   one-cycle write strobe to register bank
//  DataWr      out  8   write data, valid while Wr=1
//  RdData      in   8   register bank read data for current Addr (combinational mux outside)
//  Rd          out  1   one-cycle read strobe, asserted on the cycle RdData is captured
// BEHAVIOUR
//  Reset (PciReset=1 at posedge): state=IDLE, LAD_oe=0, LAD_out=4'hF, Addr=0, Wr=0, DataWr=0, Rd=0.
//  Nibble order: address MSN first (4 nibbles, 16-bit I/O address); data LSN first (2 nibbles).
//  States: IDLE, START, CYC, ADDR(x4), WDATA(x2), HTAR(x2), SYNC, RDATA(x2), TTAR(x2).
//  START detect, from ANY state: LFrame_n=0 & LAD_in=4'h0 -> START (aborts any cycle in progress,
//    LAD_oe=0 next cycle). LFrame_n=0 & LAD_in!=0 -> IDLE (abort / other start code).
//  START: stays while LFrame_n=0; first cycle with LFrame_n=1 samples LAD_in as CYCTYPE/DIR.
//    LAD_in[3:1]=3'b000 -> I/O read; 3'b001 -> I/O write; any other value -> IDLE (ignored).
//  ADDR: 4 cycles, shift in 16-bit address. After the 4th nibble, hit = addr[15:n]==BASE_ADDR[15:n],
//    where n = log2(NUM_REGS). On a miss, go to IDLE, never drive LAD, and raise no strobes.
//    On a hit, Addr is registered on the cycle after the 4th nibble and held until the next hit.
//  Write: WDATA 2 cycles (capture LSN then MSN), HTAR 2 cycles (host turnaround, LAD_oe=0),
//    SYNC: LAD_oe=1, LAD_out=4'h0, Wr=1 and DataWr valid in this same cycle (exactly 1 clock),
//    TTAR: cycle1 LAD_oe=1 LAD_out=4'hF; cycle2 LAD_oe=0; then IDLE.
//  Read: HTAR 2 cycles (LAD_oe=0), SYNC: LAD_oe=1 LAD_out=4'h0, Rd=1, RdData latched at end of cycle,
//    RDATA: LAD_out=data[3:0] then data[7:4], TTAR as for write; then IDLE.
//  Latency: SYNC always ready (no long-wait); Wr fires 9 clocks after the CYC nibble (CYC=clk0).
//  A START detected mid-cycle overrides all: Wr/Rd are not issued if START occurs before SYNC.
//  PciReset mid-cycle: immediate return to reset values; no partial Wr/Rd.
//  LAD_oe is never 1 in IDLE, START, CYC, ADDR, WDATA or HTAR.
// STRUCTURE
//  lpc_pkg: state enum lpc_state_t; constants LPC_START=4'h0, LPC_SYNC_READY=4'h0, LPC_TAR=4'hF,
//    CYC_IO_RD=3'b000, CYC_IO_WR=3'b001.
//  Single flat module; nibble counter (2-bit) shared by ADDR/WDATA/TAR/RDATA. No sub-module.
// TESTING
//  1 IO write 0x0805<=0x3C (LAD: 0,2,0,8,0,5,C,3) -> SYNC=0 driven, Wr=1 one clk, Addr=5, DataWr=3C.
//  2 IO read 0x081F, RdData=5A -> Rd=1 in SYNC; LAD_out sequence 0,A,5,F, then LAD_oe=0.
//  3 IO write 0x0905 (miss) -> LAD_oe stays 0 whole cycle; Wr never asserted.
//  4 Memory cycle CYCTYPE=4'h4 at any address -> ignored, LAD_oe=0, back to IDLE.
//  5 LFrame_n=0,LAD=F during WDATA -> abort to IDLE, no Wr; next valid write completes normally.
//  6 PciReset=1 during HTAR of a read -> next clock all outputs at reset values; Rd never pulses.

Source files
------------

// File: rtl/lpc_pkg.sv
// Shared types and LPC protocol constants for the LPC I/O target.
package lpc_pkg;

  // The cycle-type nibble is decoded on the START -> ADDR transition, so there is no separate CYC state.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_WDATA,
    ST_HTAR,
    ST_SYNC,
    ST_RDATA,
    ST_TTAR
  } lpc_state_t;

  localparam logic [3:0] LPC_START      = 4'h0;
  localparam logic [3:0] LPC_SYNC_READY = 4'h0;
  localparam logic [3:0] LPC_TAR        = 4'hF;

  localparam logic [2:0] CYC_IO_RD = 3'b000;
  localparam logic [2:0] CYC_IO_WR = 3'b001;

endpackage

// File: rtl/lpc_io_target.sv
// LPC I/O target: decodes host I/O read/write cycles on LFrame_n/LAD and maps them
// onto byte accesses to a NUM_REGS-byte register window at BASE_ADDR.
module lpc_io_target
  import lpc_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0800,
  parameter int unsigned NUM_REGS  = 32
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic       LFrame_n,
  input  logic [3:0] LAD_in,
  output logic [3:0] LAD_out,
  output logic       LAD_oe,
  output logic [7:0] Addr,
  output logic       Wr,
  output logic [7:0] DataWr,
  input  logic [7:0] RdData,
  output logic       Rd
);

  localparam logic [7:0]  IDX_MASK = 8'(NUM_REGS - 1);
  localparam logic [15:0] HI_MASK  = ~16'(NUM_REGS - 1);

  lpc_state_t  state, state_next;
  logic [1:0]  cnt, cnt_next;
  logic        is_write, is_write_next;
  logic [11:0] addr_sh;
  logic [7:0]  rd_q;
  logic [15:0] addr_full;
  logic        addr_hit;

  // Address as it stands once the current nibble is shifted in; only meaningful on the 4th ADDR cycle.
  assign addr_full = {addr_sh, LAD_in};
  assign addr_hit  = ((addr_full ^ BASE_ADDR) & HI_MASK) == 16'h0000;

  always_ff @(posedge LpcClock) begin
    if (PciReset) begin
      state    <= ST_IDLE;
      cnt      <= 2'd0;
      is_write <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      is_write <= is_write_next;
    end
  end

  // LFrame_n low overrides everything: a START code restarts framing, any other code abandons the cycle.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt + 2'd1;
    is_write_next = is_write;
    if (!LFrame_n) begin
      state_next = (LAD_in == LPC_START) ? ST_START : ST_IDLE;
      cnt_next   = 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_next = 2'd0;
        end
        ST_START: begin
          cnt_next = 2'd0;
          if (LAD_in[3:1] == CYC_IO_RD) begin
            state_next    = ST_ADDR;
            is_write_next = 1'b0;
          end else if (LAD_in[3:1] == CYC_IO_WR) begin
            state_next    = ST_ADDR;
            is_write_next = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (cnt == 2'd3) begin
            cnt_next = 2'd0;
            if (addr_hit) state_next = is_write ? ST_WDATA : ST_HTAR;
            else          state_next = ST_IDLE;
          end
        end
        ST_WDATA: begin
          if (cnt == 2'd1) begin
            cnt_next   = 2'd0;
            state_next = ST_HTAR;
          end
        end
        ST_HTAR: begin
          if (cnt == 2'd1) begin
            cnt_next   = 2'd0;
            state_next = ST_SYNC;
          end
        end
        ST_SYNC: begin
          cnt_next   = 2'd0;
          state_next = is_write ? ST_TTAR : ST_RDATA;
        end
        ST_RDATA: begin
          if (cnt == 2'd1) begin
            cnt_next   = 2'd0;
            state_next = ST_TTAR;
          end
        end
        ST_TTAR: begin
          if (cnt == 2'd1) begin
            cnt_next   = 2'd0;
            state_next = ST_IDLE;
          end
        end
        default: begin
          cnt_next   = 2'd0;
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Datapath only advances on cycles the host is not asserting LFrame_n.
  always_ff @(posedge LpcClock) begin
    if (PciReset) begin
      addr_sh <= 12'h000;
      Addr    <= 8'h00;
      DataWr  <= 8'h00;
      rd_q    <= 8'h00;
    end else if (LFrame_n) begin
      case (state)
        ST_ADDR: begin
          addr_sh <= addr_full[11:0];
          if (cnt == 2'd3 && addr_hit) Addr <= addr_full[7:0] & IDX_MASK;
        end
        ST_WDATA: DataWr <= {LAD_in, DataWr[7:4]};
        ST_SYNC:  if (!is_write) rd_q <= RdData;
        default: ;
      endcase
    end
  end

  always_comb begin
    LAD_oe  = 1'b0;
    LAD_out = LPC_TAR;
    Wr      = 1'b0;
    Rd      = 1'b0;
    case (state)
      ST_SYNC: begin
        LAD_oe  = 1'b1;
        LAD_out = LPC_SYNC_READY;
        Wr      = is_write;
        Rd      = !is_write;
      end
      ST_RDATA: begin
        LAD_oe  = 1'b1;
        LAD_out = cnt[0] ? rd_q[7:4] : rd_q[3:0];
      end
      ST_TTAR: begin
        LAD_oe  = (cnt == 2'd0);
        LAD_out = LPC_TAR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lpc_io_target.sv
// Directed + randomized bench for lpc_io_target against a transaction-level model of
// LPC I/O cycles and a 32-byte register window at 0x0800.
module tb_lpc_io_target;

  localparam int NCYC = 15;
  localparam int NO_EVENT = 99;

  logic       clock = 1'b0;
  logic       reset;
  logic       lframe_n;
  logic [3:0] lad_in;
  logic [3:0] lad_out;
  logic       lad_oe;
  logic [7:0] addr;
  logic       wr;
  logic [7:0] data_wr;
  logic [7:0] rd_data;
  logic       rd;

  int total = 0;
  int bad = 0;

  logic [7:0] bank [256];
  logic [7:0] model_regs [32];
  logic [7:0] model_addr;

  logic [NCYC-1:0] ob_oe, ob_wr, ob_rd;
  logic [3:0]      ob_out [NCYC];
  logic [7:0]      ob_addr [NCYC];
  logic [7:0]      ob_dw [NCYC];

  always #5 clock = ~clock;

  lpc_io_target dut (
    .LpcClock(clock),
    .PciReset(reset),
    .LFrame_n(lframe_n),
    .LAD_in(lad_in),
    .LAD_out(lad_out),
    .LAD_oe(lad_oe),
    .Addr(addr),
    .Wr(wr),
    .DataWr(data_wr),
    .RdData(rd_data),
    .Rd(rd)
  );

  // External register bank the target reads from and writes into.
  assign rd_data = bank[addr];
  always @(posedge clock) if (wr) bank[addr] <= data_wr;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One host frame: START, cycle type, 4 address nibbles, 2 data nibbles, then idle host drive.
  // abort_at / reset_at pick a cycle index where the host aborts or reset is asserted.
  task automatic applyStimulus(input string name, input logic [3:0] cyc, input logic [15:0] io_addr,
                               input logic [7:0] data, input int abort_at, input int reset_at);
    logic [3:0]      host [NCYC];
    logic            valid, is_wr, hit, act, fire;
    int              cut, sync, len;
    logic [NCYC-1:0] exp_oe, exp_wr, exp_rd;
    logic [4:0]      idx;
    for (int j = 0; j < NCYC; j++) host[j] = 4'hF;
    host[0] = 4'h0;
    host[1] = cyc;
    host[2] = io_addr[15:12];
    host[3] = io_addr[11:8];
    host[4] = io_addr[7:4];
    host[5] = io_addr[3:0];
    host[6] = data[3:0];
    host[7] = data[7:4];
    for (int j = 0; j < NCYC; j++) begin
      @(negedge clock);
      ob_oe[j]   = lad_oe;
      ob_wr[j]   = wr;
      ob_rd[j]   = rd;
      ob_out[j]  = lad_out;
      ob_addr[j] = addr;
      ob_dw[j]   = data_wr;
      lframe_n   = !(j == 0 || j == abort_at);
      lad_in     = (j == abort_at) ? 4'hF : host[j];
      reset      = (j == reset_at);
    end

    valid = (cyc[3:1] == 3'd0) || (cyc[3:1] == 3'd1);
    is_wr = (cyc[3:1] == 3'd1);
    hit   = (io_addr & 16'hFFE0) == 16'h0800;
    act   = valid && hit;
    idx   = io_addr[4:0];
    cut   = (abort_at < reset_at) ? abort_at : reset_at;
    sync  = is_wr ? 10 : 8;
    len   = is_wr ? 2 : 4;
    fire  = act && (sync <= cut);
    exp_oe = '0;
    exp_wr = '0;
    exp_rd = '0;
    for (int j = 0; j < NCYC; j++)
      if (act && j >= sync && j < sync + len && j <= cut) exp_oe[j] = 1'b1;
    if (fire && is_wr)  exp_wr[sync] = 1'b1;
    if (fire && !is_wr) exp_rd[sync] = 1'b1;

    checkOutput({name, ".oe"}, 32'(ob_oe), 32'(exp_oe));
    checkOutput({name, ".wr"}, 32'(ob_wr), 32'(exp_wr));
    checkOutput({name, ".rd"}, 32'(ob_rd), 32'(exp_rd));
    if (fire && cut >= sync + len) begin
      checkOutput({name, ".sync"}, 32'(ob_out[sync]), 32'h0);
      if (is_wr) begin
        checkOutput({name, ".datawr"}, 32'(ob_dw[sync]), 32'(data));
        checkOutput({name, ".ttar"}, 32'(ob_out[sync+1]), 32'hF);
        model_regs[idx] = data;
      end else begin
        checkOutput({name, ".lsn"}, 32'(ob_out[sync+1]), 32'(model_regs[idx][3:0]));
        checkOutput({name, ".msn"}, 32'(ob_out[sync+2]), 32'(model_regs[idx][7:4]));
        checkOutput({name, ".ttar"}, 32'(ob_out[sync+3]), 32'hF);
      end
    end
    if (act && cut > 5) model_addr = {3'b000, idx};
    if (reset_at < NCYC - 1) begin
      model_addr = 8'h00;
      checkOutput({name, ".rstvals"},
                  {10'h0, ob_oe[reset_at+1], ob_out[reset_at+1], ob_wr[reset_at+1], ob_rd[reset_at+1],
                   ob_addr[reset_at+1], ob_dw[reset_at+1]},
                  {10'h0, 1'b0, 4'hF, 1'b0, 1'b0, 8'h00, 8'h00});
    end
    checkOutput({name, ".addr"}, 32'(ob_addr[NCYC-1]), 32'(model_addr));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [3:0]  cyc;
    logic [15:0] a;
    int          r;
    for (int i = 0; i < 256; i++) bank[i] = 8'($urandom);
    for (int i = 0; i < 32; i++) model_regs[i] = bank[i];
    bank[31] = 8'h5A;
    model_regs[31] = 8'h5A;
    model_addr = 8'h00;
    reset = 1'b1;
    lframe_n = 1'b1;
    lad_in = 4'hF;
    repeat (3) @(negedge clock);
    checkOutput("reset", {10'h0, lad_oe, lad_out, wr, rd, addr, data_wr},
                {10'h0, 1'b0, 4'hF, 1'b0, 1'b0, 8'h00, 8'h00});
    reset = 1'b0;

    applyStimulus("io_wr_0805", 4'h2, 16'h0805, 8'h3C, NO_EVENT, NO_EVENT);
    applyStimulus("io_rd_081f", 4'h0, 16'h081F, 8'h00, NO_EVENT, NO_EVENT);
    applyStimulus("io_wr_miss", 4'h2, 16'h0905, 8'hA7, NO_EVENT, NO_EVENT);
    applyStimulus("mem_cycle", 4'h4, 16'h0805, 8'h11, NO_EVENT, NO_EVENT);
    applyStimulus("wr_abort", 4'h2, 16'h0803, 8'h96, 7, NO_EVENT);
    applyStimulus("wr_after_abort", 4'h3, 16'h0803, 8'h69, NO_EVENT, NO_EVENT);
    applyStimulus("rd_back", 4'h1, 16'h0803, 8'h00, NO_EVENT, NO_EVENT);
    applyStimulus("rd_reset", 4'h0, 16'h0810, 8'h00, NO_EVENT, 6);

    for (int t = 0; t < 30; t++) begin
      r = int'($urandom_range(0, 7));
      cyc = (r < 6) ? 4'(r % 4) : 4'($urandom_range(4, 15));
      a = ($urandom_range(0, 2) != 0) ? (16'h0800 | 16'($urandom_range(0, 31))) : 16'($urandom);
      applyStimulus("random", cyc, a, 8'($urandom), NO_EVENT, NO_EVENT);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
